dec_frame_loader: RTL

DEC_FRAME_LOADER -- requirements
Module: dec_frame_loader

---
 rtl/dec_frame_loader_pkg.sv | 17 +
 rtl/dec_frame_loader_if.sv | 22 ++
 rtl/dec_frame_loader_frame_buf.sv | 50 +++++
 rtl/dec_frame_loader.sv | 84 ++++++++
 4 files changed

// File: rtl/dec_frame_loader_pkg.sv
// dec_frame_loader_pkg: frame geometry, buffer state encoding and shared types for the ping-pong frame loader
package dec_frame_loader_pkg;
    localparam int MAX_CODE_RATE   = 2;
    localparam int TRACEBACK_DEPTH = 16;
    localparam int SYMS_PER_FRAME  = TRACEBACK_DEPTH / MAX_CODE_RATE;
    localparam int CNT_W           = $clog2(SYMS_PER_FRAME + 1);

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'b00,
        BUF_FILLING = 2'b01,
        BUF_FULL    = 2'b10
    } buf_state_e;

    typedef logic [MAX_CODE_RATE-1:0]   sym_t;
    typedef logic [TRACEBACK_DEPTH-1:0] frame_t;
    typedef logic [CNT_W-1:0]           cnt_t;
endpackage

// File: rtl/dec_frame_loader_if.sv
// dec_frame_loader_if: symbol stream in, frame handshake out; master = symbol source / decoder side, slave = loader
interface dec_frame_loader_if;
    import dec_frame_loader_pkg::*;
    sym_t        i_sym;
    logic        i_sym_valid;
    logic        o_sym_ready;
    logic        i_flush;
    frame_t      o_frame_data;
    logic        o_frame_valid;
    logic        i_frame_ack;
    logic [15:0] o_frame_cnt;

    modport master (
        output i_sym, i_sym_valid, i_flush, i_frame_ack,
        input  o_sym_ready, o_frame_data, o_frame_valid, o_frame_cnt
    );

    modport slave (
        input  i_sym, i_sym_valid, i_flush, i_frame_ack,
        output o_sym_ready, o_frame_data, o_frame_valid, o_frame_cnt
    );
endinterface

// File: rtl/dec_frame_loader_frame_buf.sv
// dec_frame_loader_frame_buf: one frame buffer -- symbol write at MSB-first slot, zero-padded close, EMPTY/FILLING/FULL state
module dec_frame_loader_frame_buf
    import dec_frame_loader_pkg::*;
(
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       wr,
    input  logic       flush,
    input  logic       clr,
    input  sym_t       sym,
    input  cnt_t       idx,
    output buf_state_e state,
    output frame_t     data,
    output logic       done
);
    buf_state_e state_n;
    frame_t     data_n;
    logic       last;
    logic       close;

    // Buffer state and contents
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state <= BUF_EMPTY;
            data  <= '0;
        end else begin
            state <= state_n;
            data  <= data_n;
        end
    end

    // Next state/contents: the incoming symbol lands first, then a close clears every slot past it
    always_comb begin
        state_n = clr ? BUF_EMPTY : done ? BUF_FULL : wr ? BUF_FILLING : state;
        data_n  = data;
        for (int k = 0; k < SYMS_PER_FRAME; k++) begin
            if (wr && cnt_t'(k) == idx)
                data_n[TRACEBACK_DEPTH-1-k*MAX_CODE_RATE -: MAX_CODE_RATE] = sym;
            if (close && k >= int'(idx) + int'(wr))
                data_n[TRACEBACK_DEPTH-1-k*MAX_CODE_RATE -: MAX_CODE_RATE] = '0;
        end
    end

    // Completion: last slot written, or a flush while the buffer holds (or is receiving) data
    always_comb begin
        last  = wr && idx == cnt_t'(SYMS_PER_FRAME - 1);
        close = flush && (wr || state == BUF_FILLING);
        done  = last || close;
    end
endmodule

// File: rtl/dec_frame_loader.sv
// dec_frame_loader: ping-pong symbol-to-frame loader for the decoder; optional LOADER_OVERFLOW_STATUS_EN adds o_overflow/o_drop_cnt
module dec_frame_loader
    import dec_frame_loader_pkg::*;
(
    input  logic               sys_clk,
    input  logic               rst,
    input  logic               en,
    dec_frame_loader_if.slave  bus
`ifdef LOADER_OVERFLOW_STATUS_EN
    ,
    output logic               o_overflow,
    output logic [7:0]         o_drop_cnt
`endif
);
    logic        wr_ptr;
    logic        rd_ptr;
    cnt_t        cnt;
    logic [15:0] frame_cnt;
    buf_state_e  st [2];
    frame_t      dat [2];
    logic [1:0]  done;
    logic        accept;
    logic        ack;

    assign accept = en && bus.i_sym_valid && bus.o_sym_ready;
    assign ack    = en && bus.i_frame_ack && bus.o_frame_valid;

    for (genvar b = 0; b < 2; b++) begin : g_buf
        dec_frame_loader_frame_buf u_buf (
            .sys_clk (sys_clk),
            .rst     (rst),
            .wr      (accept && wr_ptr == 1'(b)),
            .flush   (en && bus.i_flush && wr_ptr == 1'(b)),
            .clr     (ack && rd_ptr == 1'(b)),
            .sym     (bus.i_sym),
            .idx     (cnt),
            .state   (st[b]),
            .data    (dat[b]),
            .done    (done[b])
        );
    end

    // Write side moves to the other buffer on completion; read side advances and counts on ack
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            cnt       <= '0;
            frame_cnt <= '0;
        end else begin
            if (|done) begin
                wr_ptr <= ~wr_ptr;
                cnt    <= '0;
            end else if (accept) begin
                cnt <= cnt + 1'b1;
            end
            if (ack) begin
                rd_ptr    <= ~rd_ptr;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    assign bus.o_sym_ready   = st[wr_ptr] != BUF_FULL;
    assign bus.o_frame_valid = st[rd_ptr] == BUF_FULL;
    assign bus.o_frame_data  = dat[rd_ptr];
    assign bus.o_frame_cnt   = frame_cnt;

`ifdef LOADER_OVERFLOW_STATUS_EN
    logic drop;
    assign drop = en && bus.i_sym_valid && !bus.o_sym_ready;

    // Sticky overflow flag and saturating count of refused symbol cycles
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            o_overflow <= 1'b0;
            o_drop_cnt <= '0;
        end else if (drop) begin
            o_overflow <= 1'b1;
            if (o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
        end
    end
`endif
endmodule
